// File: rtl/exu_wb.sv
// exu_wb: merges the ALU and LSU result streams onto one registered register-file write port.
// Optional WB_LSU_BYPASS_EN lets a load skip the FIFO when it is empty and the ALU is idle.
module exu_wb #(
  parameter int XLEN  = 32,
  parameter int RFIDX = 5,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_alu_rdwen,
  input  logic [RFIDX-1:0] i_alu_rdidx,
  input  logic [XLEN-1:0]  i_alu_rdwdata,
  input  logic             i_lsu_valid,
  output logic             o_lsu_ready,
  input  logic [RFIDX-1:0] i_lsu_rdidx,
  input  logic [XLEN-1:0]  i_lsu_rdwdata,
  output logic             o_wb_stall,
  output logic             o_rf_wen,
  output logic [RFIDX-1:0] o_rf_widx,
  output logic [XLEN-1:0]  o_rf_wdata,
  output logic             o_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic [DEPTH-1:0] vld;
  logic [RFIDX-1:0] idx [DEPTH];
  logic [XLEN-1:0]  dat [DEPTH];
  logic             alu_wr, acc, disc, empty, deq, head_wr, byp, enq;
  logic [RFIDX-1:0] wr_idx;
  logic [XLEN-1:0]  wr_dat;
  assign o_lsu_ready = count != FULL;
  assign o_wb_stall  = count == FULL;
  assign empty       = count == '0;
  assign o_busy      = !empty || o_rf_wen;
  assign alu_wr      = i_alu_rdwen && |i_alu_rdidx;
  assign acc         = i_lsu_valid && o_lsu_ready;
  // x0 loads and loads overwritten by a same-cycle ALU write are accepted but dropped
  assign disc        = ~|i_lsu_rdidx || (alu_wr && i_lsu_rdidx == i_alu_rdidx);
  assign deq         = !alu_wr && !empty;
  assign head_wr     = deq && vld[rptr];
`ifdef WB_LSU_BYPASS_EN
  assign byp         = acc && !disc && !alu_wr && empty;
`else
  assign byp         = 1'b0;
`endif
  assign enq         = acc && !disc && !byp;
  always_comb begin
    wr_idx = alu_wr ? i_alu_rdidx   : head_wr ? idx[rptr] : i_lsu_rdidx;
    wr_dat = alu_wr ? i_alu_rdwdata : head_wr ? dat[rptr] : i_lsu_rdwdata;
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      vld        <= '0;
      o_rf_wen   <= 1'b0;
      o_rf_widx  <= '0;
      o_rf_wdata <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx[i] <= '0;
        dat[i] <= '0;
      end
    end else begin
      o_rf_wen <= alu_wr || head_wr || byp;
      if (alu_wr || head_wr || byp) begin
        o_rf_widx  <= wr_idx;
        o_rf_wdata <= wr_dat;
      end
      for (int i = 0; i < DEPTH; i++)
        if (alu_wr && idx[i] == i_alu_rdidx) vld[i] <= 1'b0;
      if (deq) begin
        vld[rptr] <= 1'b0;
        rptr      <= rptr + AW'(1);
      end
      if (enq) begin
        vld[wptr] <= 1'b1;
        idx[wptr] <= i_lsu_rdidx;
        dat[wptr] <= i_lsu_rdwdata;
        wptr      <= wptr + AW'(1);
      end
      count <= count + (AW+1)'(enq) - (AW+1)'(deq);
    end
  end
endmodule
